uart_asc_num_multi: RTL
=======================

Name: uart_asc_num_multi

Overview:
Parametrised successor of the UART ASCII-to-number converter. It sits after the UART receiver and consumes one received byte per strobe. It parses a text line of CH signed or unsigned decimal fields separated by ',' and ended by CR or LF. On a well-formed line it latches all CH values together and pulses valid; malformed lines are discarded and reported.

Parameters:
CH, 3, number of fields (channels) per line, 1..16
DW, 32, width of each output value in bits, 8..32
SIGNED, 1, 1 = optional leading '-' allowed and outputs are two's complement; 0 = unsigned only

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
asc  input  8  received ASCII byte, qualified by start
start  input  1  byte-available strobe from UART rx; rising-edge detected internally
dataerror  input  1  parity error for the current byte, sampled with start
frameerror  input  1  stop-bit error for the current byte, sampled with start
clr  input  1  synchronous clear, abort the current line
data_out  output  CH*DW  latched values; channel k occupies [k*DW +: DW]
valid  output  1  one-cycle pulse when data_out has been updated
frame_err  output  1  one-cycle pulse when a line was rejected
ovf  output  1  level; set with valid if any field saturated; held until the next valid or frame_err

Behaviour:
- Reset (async, rst=1): data_out=0, valid=0, frame_err=0, ovf=0, state=IDLE, field index=0, accumulators=0, edge-detect register=0.
- Byte event: start=1 while the previous-cycle start=0. Holding start high for many cycles yields one event. The event is processed in the same cycle; all resulting outputs update on the next clock edge (1-cycle latency).
- Character classes: digit '0'..'9'; sign '-' (0x2D); separator ',' (0x2C); terminator CR (0x0D) or LF (0x0A); anything else is invalid.
- States:
  - IDLE: no field content yet.
    - Digit -> FIELD with acc=digit.
    - '-' (SIGNED=1) -> SIGN with neg=1.
    - Terminator -> stay IDLE, no pulse. This makes CR LF pairs and blank lines harmless.
    - Separator, invalid, '-' with SIGNED=0, or any byte with dataerror/frameerror -> DISCARD.
  - SIGN: only a digit is accepted -> FIELD. Anything else -> DISCARD.
  - FIELD:
    - Digit: acc = acc*10 + digit, computed as (acc<<3)+(acc<<1)+digit in DW+4 bits.
    - Separator:
      - If index < CH-1: store the signed field in the staging register, index++, next state is SEP.
      - If index = CH-1: DISCARD.
    - Terminator:
      - If index = CH-1: store the last field, copy staging to data_out, pulse valid, drive ovf from the line's sticky overflow, then IDLE.
      - If index < CH-1: pulse frame_err and go to IDLE.
    - Invalid or error byte -> DISCARD.
  - SEP: same as IDLE, except a terminator is an error: pulse frame_err, go to IDLE. An empty trailing field is illegal.
  - DISCARD: ignore bytes until a terminator, then pulse frame_err and go to IDLE. Error flags on the terminator byte itself are ignored.
- Saturation limit: 2^(DW-1)-1 when SIGNED=1, otherwise 2^DW-1.
  - If acc*10+digit exceeds the limit, clamp acc to the limit and set the line's sticky ovf_pend.
  - Negative fields store -acc, so the minimum output is -(2^(DW-1)-1).
  - "-0" stores 0.
- data_out changes only on valid. A rejected line leaves the previous values intact. ovf is cleared on frame_err.
- clr (synchronous) has priority over a byte event in the same cycle:
  - state=IDLE, index=0, acc=0, staging=0, ovf_pend=0.
  - data_out=0, ovf=0.
  - No valid or frame_err pulse.
- valid and frame_err are never asserted in the same cycle.
- CH=1: the separator is always an error; a line is a single field plus terminator.

Test Plan:
- CH=3, DW=32, SIGNED=1; bytes "12,-34,5\n", each start held 1 cycle with 10-cycle gaps -> one cycle after '\n': valid=1 for exactly 1 cycle, data_out ch0=0x0000000C, ch1=0xFFFFFFDE, ch2=0x00000005, ovf=0, frame_err=0.
- Same line but each start held high 10 cycles, then "\r\n" terminator -> identical values, one valid only; the trailing LF produces no pulse.
- "99999999999,0,-7\n" -> ch0=0x7FFFFFFF, ch1=0, ch2=0xFFFFFFF9, valid with ovf=1; next line "1,2,3\n" -> valid with ovf=0.
- After the first test, send "1,2\n", then "1,,3\n", then "1,a,3\n" -> three frame_err pulses, no valid, data_out still 12/-34/5.
- "4,5" with dataerror=1 on '5', then ",6\n" -> frame_err; next "4,5,6\n" -> valid, data_out 4/5/6.
- Mid-line "7,8" then clr=1 for 1 cycle, then "1,1,1\n" -> data_out=0 right after clr with no pulse, then valid with 1/1/1. Also assert rst asynchronously mid-line -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_asc_num_multi_if.sv
// Byte-stream and result bus between a UART receiver front end and the
// multi-field ASCII-to-number converter.
interface uart_asc_num_multi_if #(
    parameter int CH = 3,
    parameter int DW = 32
);
    logic [7:0]       asc;
    logic             start;
    logic             dataerror;
    logic             frameerror;
    logic             clr;
    logic [CH*DW-1:0] data_out;
    logic             valid;
    logic             frame_err;
    logic             ovf;

    modport master (
        output asc, start, dataerror, frameerror, clr,
        input  data_out, valid, frame_err, ovf
    );

    modport slave (
        input  asc, start, dataerror, frameerror, clr,
        output data_out, valid, frame_err, ovf
    );
endinterface

// File: rtl/uart_asc_num_multi.sv
// Parses lines of CH comma-separated decimal fields ended by CR/LF and
// latches all fields together with a valid pulse; bad lines raise frame_err.
module uart_asc_num_multi #(
    parameter int CH     = 3,
    parameter int DW     = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_asc_num_multi_if.slave  bus
);
    localparam int IW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [IW-1:0] LAST = IW'(CH - 1);
    localparam logic [DW+3:0] LIMIT = SIGNED ? (DW+4)'((64'd1 << (DW - 1)) - 64'd1)
                                             : (DW+4)'((64'd1 << DW) - 64'd1);

    typedef enum logic [2:0] {IDLE, SIGN, FIELD, SEP, DISCARD} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic             neg_q, neg_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [CH*DW-1:0] stage_q, stage_d;
    logic [CH*DW-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             ovf_q, ovf_d;
    logic             start_q;

    logic          byte_ev, byte_err;
    logic          is_digit, is_minus, is_sep, is_term;
    logic [3:0]    dval;
    logic [DW+3:0] acc_mul;
    logic          sat_over;
    logic [DW-1:0] acc_sat, fld_val;
    logic          line_done, line_fail;

    assign byte_ev  = bus.start && !start_q;
    assign byte_err = bus.dataerror || bus.frameerror;
    assign is_digit = (bus.asc >= 8'h30) && (bus.asc <= 8'h39);
    assign is_minus = (bus.asc == 8'h2D);
    assign is_sep   = (bus.asc == 8'h2C);
    assign is_term  = (bus.asc == 8'h0D) || (bus.asc == 8'h0A);
    assign dval     = bus.asc[3:0];

    // acc*10 + digit without a multiplier; the 4 extra bits cannot overflow.
    assign acc_mul  = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {{DW{1'b0}}, dval};
    assign sat_over = acc_mul > LIMIT;
    assign acc_sat  = sat_over ? LIMIT[DW-1:0] : acc_mul[DW-1:0];
    assign fld_val  = neg_q ? (~acc_q + 1'b1) : acc_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        ovf_pend_d  = ovf_pend_q;
        stage_d     = stage_q;
        data_d      = data_q;
        ovf_d       = ovf_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        line_done   = 1'b0;
        line_fail   = 1'b0;

        if (bus.clr) begin
            state_d    = IDLE;
            idx_d      = '0;
            acc_d      = '0;
            neg_d      = 1'b0;
            ovf_pend_d = 1'b0;
            stage_d    = '0;
            data_d     = '0;
            ovf_d      = 1'b0;
        end else if (byte_ev) begin
            unique case (state_q)
                IDLE, SEP: begin
                    if (byte_err) begin
                        state_d = DISCARD;
                    end else if (is_digit) begin
                        state_d = FIELD;
                        acc_d   = {{(DW-4){1'b0}}, dval};
                        neg_d   = 1'b0;
                    end else if (is_minus && SIGNED) begin
                        state_d = SIGN;
                        neg_d   = 1'b1;
                    end else if (is_term) begin
                        // Blank lines are harmless; an empty trailing field is not.
                        line_fail = (state_q == SEP);
                    end else begin
                        state_d = DISCARD;
                    end
                end
                SIGN: begin
                    if (!byte_err && is_digit) begin
                        state_d = FIELD;
                        acc_d   = {{(DW-4){1'b0}}, dval};
                    end else begin
                        state_d = DISCARD;
                    end
                end
                FIELD: begin
                    if (byte_err) begin
                        state_d = DISCARD;
                    end else if (is_digit) begin
                        acc_d = acc_sat;
                        if (sat_over) ovf_pend_d = 1'b1;
                    end else if (is_sep) begin
                        if (idx_q != LAST) begin
                            stage_d[idx_q*DW +: DW] = fld_val;
                            idx_d   = idx_q + 1'b1;
                            acc_d   = '0;
                            neg_d   = 1'b0;
                            state_d = SEP;
                        end else begin
                            state_d = DISCARD;
                        end
                    end else if (is_term) begin
                        if (idx_q == LAST) begin
                            stage_d[idx_q*DW +: DW] = fld_val;
                            data_d    = stage_d;
                            valid_d   = 1'b1;
                            ovf_d     = ovf_pend_q;
                            line_done = 1'b1;
                        end else begin
                            line_fail = 1'b1;
                        end
                    end else begin
                        state_d = DISCARD;
                    end
                end
                DISCARD: line_fail = is_term;
                default: state_d = IDLE;
            endcase

            if (line_fail) begin
                frame_err_d = 1'b1;
                ovf_d       = 1'b0;
            end
            if (line_done || line_fail) begin
                state_d    = IDLE;
                idx_d      = '0;
                acc_d      = '0;
                neg_d      = 1'b0;
                ovf_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            ovf_pend_q  <= 1'b0;
            stage_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_q       <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            ovf_pend_q  <= ovf_pend_d;
            stage_q     <= stage_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            ovf_q       <= ovf_d;
            start_q     <= bus.start;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.ovf       = ovf_q;
endmodule
